btb_ctrl: RTL and testbench
===========================

# btb_ctrl

Branch target buffer controller, the initiator for the dual-port 256×32 `btb` SRAM macro. It sits beside fetch. It takes a PC lookup every cycle and returns hit and predicted target one cycle later. It installs entries from branch resolution and clears every entry by sweeping the array after reset or on a flush request.

## Interface
- IDX_W, 8, index bits: index = pc[IDX_W+1:2]; the macro depth is 2^IDX_W.
- TAG_W, 9, tag bits: tag = pc[IDX_W+TAG_W+1:IDX_W+2]; the offset width OFF_W = 31-TAG_W (22).
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  fetch lookup request; accepted every cycle.
- lookup_pc  in  32  fetch PC.
- resp_valid  out  1  response for the lookup accepted last cycle.
- resp_hit  out  1  entry valid and tag match.
- resp_target  out  32  predicted target; 0 when not hit.
- upd_valid  in  1  install request from branch resolution.
- upd_pc, upd_target  in  32 each  branch PC and taken target.
- flush  in  1  one-cycle pulse that invalidates all entries.
- busy  out  1  high while sweeping.
- sram_csb0, sram_web0  out  1 each  port 0 (write port) chip select and write enable, both active low.
- sram_addr0  out  IDX_W  port 0 address.
- sram_din0  out  32  port 0 write data.
- sram_csb1, sram_web1  out  1 each  port 1 (read port); web1 is tied to 1.
- sram_addr1  out  IDX_W  port 1 address.
- sram_dout1  in  32  port 1 read data; combinational on sram_addr1.

## Operation
- Entry format: [31] valid, [30:OFF_W] tag, [OFF_W-1:0] target[OFF_W+1:2]. Reconstructed target = {pc[31:OFF_W+2], offset, 2'b00}.
- FSM states:
  - FLUSH: cnt runs 0..255. Drive csb0=0, web0=0, addr0=cnt, din0=0. At cnt=255, go to RUN.
  - RUN: normal operation. A flush pulse goes to FLUSH with cnt=0. A flush pulse while in FLUSH restarts cnt at 0.
- Lookup pipeline:
  - Cycle N: register {valid, pc, in_flush}.
  - Cycle N+1: drive csb1=0 and addr1 = the registered index, compare sram_dout1 against the tag, drive the resp_* outputs combinationally from the stage register and dout1.
  - csb1=1 when the stage is empty.
- A lookup accepted in FLUSH (or in the cycle of a flush pulse) responds resp_valid=1, resp_hit=0.
- Update in RUN with upd_pc[31:OFF_W+2]==upd_target[31:OFF_W+2]:
  - Same cycle: csb0=0, web0=0, addr0=index, din0={1, tag, upd_target[OFF_W+1:2]}.
  - Otherwise the update is dropped.
- Updates during FLUSH are dropped.
- When neither a sweep nor an update is active, csb0=1 and web0=1.
- Visibility: a lookup in cycle N sees updates from cycle N-1 or earlier and never one from cycle N. This follows from the macro's latch-then-write port 0. No bypass is required.
- Last sweep write: it lands one edge after leaving FLUSH, so the first lookup in RUN reads cleared data.

## Timing
- Reset values:
  - state=FLUSH, cnt=0, busy=1.
  - resp_valid=0, resp_hit=0, resp_target=0.
  - csb0=csb1=1, web0=web1=1, addr0=addr1=0, din0=0.
  - Stage register cleared; statistics counters=0.
- Sweep length: busy is high for exactly 256 cycles after rst deasserts or after a flush pulse.
- Reset mid-sweep: the sweep restarts from 0.
- Lookup latency: 1 cycle. Throughput: one lookup and one update per cycle.
- Simultaneous update and sweep: the sweep owns port 0 and the update is dropped.

## Configuration
- BTB_STATS_EN defined:
  - Adds outputs stat_lookups, stat_hits, stat_drops, each 32 bits, wrapping.
  - stat_lookups and stat_hits count on responses.
  - stat_drops counts dropped updates: region mismatch or during FLUSH.
  - All counters reset to 0 on rst. flush does not clear them.
- BTB_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package btb_pkg holds:
  - IDX_W, TAG_W and OFF_W.
  - The btb_entry_t packed struct {valid, tag, offset}.
  - The FSM state enum {FLUSH, RUN}.
- btb_ctrl is a single module with no sub-module. The macro is instantiated by the parent.

## Test plan
- Release rst -> busy high for exactly 256 cycles. Then lookup 0x0000_1000 -> resp_hit=0.
- Update pc=0x0000_1000, target=0x0000_2040 in cycle N:
  - Lookup in cycle N+1 -> hit, target 0x0000_2040 in N+2.
  - Lookup in cycle N -> miss.
- Alias at index 0: after that update, lookup 0x0004_1000 (tag 0x104 vs 4) -> miss. Update it -> lookup 0x0000_1000 misses.
- Update pc=0x0000_1000, target=0x0100_0000 -> dropped, lookup misses, stat_drops=1 (BTB_STATS_EN).
- Flush pulse after installs -> busy 256 cycles, lookups during the sweep respond with hit=0, all prior entries miss afterwards.
- Assert rst at sweep count 100 -> after release busy lasts 256 full cycles, addr0 restarts at 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer controller: geometry,
// the SRAM entry layout, the controller state encoding and PC field helpers.
package btb_pkg;

    localparam int IDX_W = 8;
    localparam int TAG_W = 9;
    localparam int OFF_W = 31 - TAG_W;
    localparam int REG_W = 30 - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    // One SRAM word: valid bit, tag, and word offset of the target within
    // the branch's own region.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [OFF_W-1:0] offset;
    } btb_entry_t;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } btb_state_e;

    function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[IDX_W+TAG_W+1:IDX_W+2];
    endfunction

    // Upper PC bits not stored in the entry; a target must share these
    // with its branch to be installable.
    function automatic logic [REG_W-1:0] pc_region(input logic [31:0] pc);
        return pc[31:OFF_W+2];
    endfunction

endpackage

// File: rtl/btb_ctrl.sv
// Branch target buffer controller driving a dual-port BTB SRAM macro.
// Port 0 writes (sweep clears and installs), port 1 reads lookups.
// Optional statistics counters are enabled with the BTB_STATS_EN macro.
//
// state | meaning
// ------+-------------------------------------------------------------
// FLUSH | sweeping: clear one entry per cycle, cnt 0..DEPTH-1; busy=1
// RUN   | normal lookups and installs
module btb_ctrl
    import btb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [31:0]      lookup_pc,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [31:0]      resp_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             flush,
    output logic             busy,
    output logic             sram_csb0,
    output logic             sram_web0,
    output logic [IDX_W-1:0] sram_addr0,
    output logic [31:0]      sram_din0,
    output logic             sram_csb1,
    output logic             sram_web1,
    output logic [IDX_W-1:0] sram_addr1,
    input  logic [31:0]      sram_dout1
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_drops
`endif
);

    btb_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             stg_valid_q, stg_valid_d;
    logic             stg_flush_q, stg_flush_d;
    logic [31:0]      stg_pc_q, stg_pc_d;

    logic             region_eq;
    logic             upd_ok;
    btb_entry_t       rd_entry;
    btb_entry_t       wr_entry;

    // PC bits that are neither index, tag nor region carry no information.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{stg_pc_q[1:0], stg_pc_q[OFF_W+1:IDX_W+TAG_W+2],
                              upd_pc[1:0], upd_pc[OFF_W+1:IDX_W+TAG_W+2],
                              upd_target[1:0]};

    assign region_eq = (pc_region(upd_pc) == pc_region(upd_target));
    assign upd_ok    = upd_valid && region_eq;
    assign busy      = (state_q == FLUSH);

    // Sweep/run sequencing; a flush pulse always (re)starts the sweep at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FLUSH: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (&cnt_q) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_entry = '{valid: 1'b1, tag: pc_tag(upd_pc), offset: upd_target[OFF_W+1:2]};

    // Port 0 arbitration: the sweep owns the port, otherwise a legal install.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        if (!rst) begin
            if (state_q == FLUSH) begin
                sram_csb0  = 1'b0;
                sram_web0  = 1'b0;
                sram_addr0 = cnt_q;
            end else if (upd_ok) begin
                sram_csb0  = 1'b0;
                sram_web0  = 1'b0;
                sram_addr0 = pc_index(upd_pc);
                sram_din0  = wr_entry;
            end
        end
    end

    // Lookup stage capture; a lookup seen during a sweep or flush pulse is
    // marked so it answers as a miss whatever the array returns.
    always_comb begin
        stg_valid_d = lookup_valid;
        stg_pc_d    = lookup_pc;
        stg_flush_d = (state_q == FLUSH) || flush;
    end

    // Lookup stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_q <= 1'b0;
            stg_flush_q <= 1'b0;
            stg_pc_q    <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_flush_q <= stg_flush_d;
            stg_pc_q    <= stg_pc_d;
        end
    end

    assign rd_entry   = btb_entry_t'(sram_dout1);
    assign sram_csb1  = !stg_valid_q;
    assign sram_web1  = 1'b1;
    assign sram_addr1 = stg_valid_q ? pc_index(stg_pc_q) : '0;

    // Response: tag compare against the combinational read data.
    always_comb begin
        resp_valid  = stg_valid_q;
        resp_hit    = stg_valid_q && !stg_flush_q && rd_entry.valid &&
                      (rd_entry.tag == pc_tag(stg_pc_q));
        resp_target = '0;
        if (resp_hit) begin
            resp_target = {pc_region(stg_pc_q), rd_entry.offset, 2'b00};
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, drops_q;
    logic        upd_drop;

    assign upd_drop = upd_valid && ((state_q == FLUSH) || !region_eq);

    // Wrapping event counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
            drops_q   <= '0;
        end else begin
            if (resp_valid) lookups_q <= lookups_q + 1'b1;
            if (resp_hit)   hits_q    <= hits_q + 1'b1;
            if (upd_drop)   drops_q   <= drops_q + 1'b1;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_drops   = drops_q;
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl: behavioural SRAM macro (latch-then-write port 0),
// directed scenarios and randomized traffic against a table-level model.
module tb_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_target;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic        flush;
    logic        busy;
    logic        sram_csb0, sram_web0, sram_csb1, sram_web1;
    logic [7:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout1;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_drops;
`endif

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_target  (resp_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .flush        (flush),
        .busy         (busy),
        .sram_csb0    (sram_csb0),
        .sram_web0    (sram_web0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_csb1    (sram_csb1),
        .sram_web1    (sram_web1),
        .sram_addr1   (sram_addr1),
        .sram_dout1   (sram_dout1)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits),
        .stat_drops   (stat_drops)
`endif
    );

    // SRAM macro: port 0 request latched on an edge, written on the next one.
    logic [31:0] mem [256];
    logic        lat_we = 1'b0;
    logic [7:0]  lat_addr = '0;
    logic [31:0] lat_din = '0;

    always @(posedge clk) begin
        if (lat_we) mem[lat_addr] <= lat_din;
        lat_we   <= !sram_csb0 && !sram_web0;
        lat_addr <= sram_addr0;
        lat_din  <= sram_din0;
    end

    assign sram_dout1 = mem[sram_addr1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: table of installed branches plus sweep countdown.
    bit          m_v   [256];
    logic [8:0]  m_tag [256];
    logic [31:0] m_tgt [256];
    int          busy_left = 256;
    bit          st_v = 1'b0;
    bit          st_hit = 1'b0;
    logic [31:0] st_pc = '0;
    logic [31:0] st_tgt = '0;
    int unsigned s_look = 0, s_hit = 0, s_drop = 0;

    function automatic logic [7:0] f_idx(input logic [31:0] pc);
        return pc[9:2];
    endfunction

    function automatic logic [8:0] f_tag(input logic [31:0] pc);
        return pc[18:10];
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 256; i++) m_v[i] = 1'b0;
    endtask

    task automatic cyc(input bit r, input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utg,
                       input bit fl);
        bit          match;
        bit          sweeping;
        logic [7:0]  li;
        logic [31:0] exp_din;
        rst = r; lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_target = utg; flush = fl;
        #1;
        sweeping = (busy_left > 0);
        match    = ((upc >> 24) == (utg >> 24));
        chk("resp_valid", resp_valid, st_v);
        chk("resp_hit", resp_hit, st_v && st_hit);
        chk("resp_target", resp_target, (st_v && st_hit) ? st_tgt : 32'h0);
        chk("busy", busy, sweeping || r);
        chk("csb1", sram_csb1, !st_v);
        chk("web1", sram_web1, 1'b1);
        chk("addr1", sram_addr1, st_v ? f_idx(st_pc) : 8'h0);
        if (r) begin
            chk("rst_csb0", sram_csb0, 1'b1);
            chk("rst_web0", sram_web0, 1'b1);
            chk("rst_addr0", sram_addr0, 8'h0);
            chk("rst_din0", sram_din0, 32'h0);
        end else if (sweeping) begin
            chk("sweep_csb0", sram_csb0, 1'b0);
            chk("sweep_web0", sram_web0, 1'b0);
            chk("sweep_addr0", sram_addr0, 32'(256 - busy_left));
            chk("sweep_din0", sram_din0, 32'h0);
        end else if (uv && match) begin
            exp_din = 32'h8000_0000 | (32'(f_tag(upc)) << 22) | ((utg >> 2) & 32'h003F_FFFF);
            chk("upd_csb0", sram_csb0, 1'b0);
            chk("upd_web0", sram_web0, 1'b0);
            chk("upd_addr0", sram_addr0, f_idx(upc));
            chk("upd_din0", sram_din0, exp_din);
        end else begin
            chk("idle_csb0", sram_csb0, 1'b1);
            chk("idle_web0", sram_web0, 1'b1);
        end
        if (r) begin
            s_look = 0; s_hit = 0; s_drop = 0;
        end else begin
            if (st_v) s_look++;
            if (st_v && st_hit) s_hit++;
            if (uv && (sweeping || !match)) s_drop++;
        end
        li     = f_idx(lpc);
        st_v   = lv && !r;
        st_pc  = lpc;
        st_hit = !r && !sweeping && !fl && m_v[li] && (m_tag[li] == f_tag(lpc));
        st_tgt = (lpc & 32'hFF00_0000) | (m_tgt[li] & 32'h00FF_FFFC);
        if (r) begin
            busy_left = 256;
            clear_table();
        end else begin
            if (!sweeping && uv && match) begin
                m_v[f_idx(upc)]   = 1'b1;
                m_tag[f_idx(upc)] = f_tag(upc);
                m_tgt[f_idx(upc)] = utg;
            end
            if (fl) begin
                busy_left = 256;
                clear_table();
            end else if (sweeping) begin
                busy_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(0, 1, pc, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt);
        cyc(0, 0, 32'h0, 1, pc, tgt, 0);
    endtask

    task automatic count_sweep(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            cyc(0, 1, 32'h0000_8000 + 32'($urandom_range(0, 7)) * 4, $urandom_range(0, 1),
                32'h0000_8000, 32'h0000_9000, 0);
            n++;
        end
        chk(tag, n, 256);
    endtask

    initial begin
        logic [31:0] pc, tgt, r;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        clear_table();
        rst = 1'b1; lookup_valid = 0; lookup_pc = 0; upd_valid = 0;
        upd_pc = 0; upd_target = 0; flush = 0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1, 1, 32'h1000, 1, 32'h1000, 32'h2000, 0);

        rst = 1'b0;
        #1;
        chk("first_sweep_addr0", sram_addr0, 8'h0);
        count_sweep("reset_sweep_len");

        look(32'h0000_1000);
        chk("cold_miss", resp_hit, 1'b0);
        cyc(0, 1, 32'h0000_1000, 1, 32'h0000_1000, 32'h0000_2040, 0);
        chk("same_cycle_miss", resp_hit, 1'b0);
        look(32'h0000_1000);
        chk("next_cycle_hit", resp_hit, 1'b1);
        chk("next_cycle_target", resp_target, 32'h0000_2040);

        look(32'h0004_1000);
        chk("alias_miss", resp_hit, 1'b0);
        upd(32'h0004_1000, 32'h0004_2000);
        look(32'h0000_1000);
        chk("alias_evicts", resp_hit, 1'b0);
        look(32'h0004_1000);
        chk("alias_hit_target", resp_target, 32'h0004_2000);

        upd(32'h0000_1000, 32'h0100_0000);
        look(32'h0000_1000);
        chk("region_drop_miss", resp_hit, 1'b0);
        look(32'h0004_1000);
        chk("region_drop_keeps", resp_hit, 1'b1);

        for (int i = 0; i < 8; i++) upd(32'h0000_8000 + 32'(i) * 4, 32'h0000_9000 + 32'(i) * 16);
        for (int i = 0; i < 8; i++) begin
            look(32'h0000_8000 + 32'(i) * 4);
            chk("installed_hit", resp_hit, 1'b1);
        end
        cyc(0, 1, 32'h0000_8000, 0, 32'h0, 32'h0, 1);
        chk("flush_cycle_miss", resp_hit, 1'b0);
        count_sweep("flush_sweep_len");
        for (int i = 0; i < 8; i++) begin
            look(32'h0000_8000 + 32'(i) * 4);
            chk("after_flush_miss", resp_hit, 1'b0);
        end

        cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 1);
        repeat (100) idle();
        chk("mid_sweep_addr0", sram_addr0, 8'd100);
        repeat (2) cyc(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        rst = 1'b0;
        #1;
        chk("restart_addr0", sram_addr0, 8'h0);
        count_sweep("restart_sweep_len");

        for (int k = 0; k < 3000; k++) begin
            r   = 32'($urandom_range(0, 1));
            pc  = (r << 24) | (32'($urandom_range(0, 3)) << 10) |
                  (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            tgt = ((($urandom_range(0, 99) < 85) ? r : (r ^ 32'h1)) << 24) |
                  ($urandom & 32'h00FF_FFFF);
            cyc(0, $urandom_range(0, 99) < 80, pc ^ (32'($urandom_range(0, 1)) << 10),
                $urandom_range(0, 1), pc, tgt, $urandom_range(0, 299) == 0);
        end
        repeat (2) idle();

`ifdef BTB_STATS_EN
        chk("stat_lookups", stat_lookups, s_look);
        chk("stat_hits", stat_hits, s_hit);
        chk("stat_drops", stat_drops, s_drop);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
